cla_64bit_adder: RTL and testbench



---
 rtl/cla_64bit_adder.sv | 123 ++++++++++++
 tb/tb_cla_64bit_adder.sv | 128 ++++++++++++
 2 files changed

// File: rtl/cla_64bit_adder.sv
// 64-bit carry-lookahead adder with registered sum/carry-out.
// Three-level 4-way lookahead tree over bit, group (4b) and block (16b) propagate/generate.

module cla_lookahead4 (
    input  logic [3:0] p_i,
    input  logic [3:0] g_i,
    input  logic       c_i,
    output logic [3:0] carry_c_o,
    output logic       grp_p_c_o,
    output logic       grp_g_c_o
);

    // Flat sum-of-products carries: every carry is two gate levels from its inputs.
    always_comb begin
        carry_c_o[0] = c_i;
        carry_c_o[1] = g_i[0]
                     | (p_i[0] & c_i);
        carry_c_o[2] = g_i[1]
                     | (p_i[1] & g_i[0])
                     | (p_i[1] & p_i[0] & c_i);
        carry_c_o[3] = g_i[2]
                     | (p_i[2] & g_i[1])
                     | (p_i[2] & p_i[1] & g_i[0])
                     | (p_i[2] & p_i[1] & p_i[0] & c_i);
        grp_p_c_o    = p_i[3] & p_i[2] & p_i[1] & p_i[0];
        grp_g_c_o    = g_i[3]
                     | (p_i[3] & g_i[2])
                     | (p_i[3] & p_i[2] & g_i[1])
                     | (p_i[3] & p_i[2] & p_i[1] & g_i[0]);
    end

endmodule

module cla_64bit_adder (
    input  logic        CLK,
    input  logic        reset,
    input  logic [63:0] in_a,
    input  logic [63:0] in_b,
    input  logic        cin,
    output logic [63:0] sum,
    output logic        cout
);

    localparam int unsigned W      = 64;
    localparam int unsigned GROUPS = W / 4;
    localparam int unsigned BLOCKS = GROUPS / 4;

    logic [W-1:0]      bit_p;
    logic [W-1:0]      bit_g;
    logic [W-1:0]      bit_c;
    logic [GROUPS-1:0] grp_p;
    logic [GROUPS-1:0] grp_g;
    logic [GROUPS-1:0] grp_c;
    logic [BLOCKS-1:0] blk_p;
    logic [BLOCKS-1:0] blk_g;
    logic [BLOCKS-1:0] blk_c;
    logic              top_p;
    logic              top_g;
    logic              c64;
    logic [W-1:0]      sum_d;
    logic [W-1:0]      sum_q;
    logic              cout_d;
    logic              cout_q;

    always_comb begin
        bit_p = in_a ^ in_b;
        bit_g = in_a & in_b;
    end

    // Level 1: 4-bit groups, carries into each bit.
    for (genvar j = 0; j < GROUPS; j++) begin : g_lvl1
        cla_lookahead4 u_grp (
            .p_i       (bit_p[4*j +: 4]),
            .g_i       (bit_g[4*j +: 4]),
            .c_i       (grp_c[j]),
            .carry_c_o (bit_c[4*j +: 4]),
            .grp_p_c_o (grp_p[j]),
            .grp_g_c_o (grp_g[j])
        );
    end

    // Level 2: 16-bit blocks, carries into each group.
    for (genvar k = 0; k < BLOCKS; k++) begin : g_lvl2
        cla_lookahead4 u_blk (
            .p_i       (grp_p[4*k +: 4]),
            .g_i       (grp_g[4*k +: 4]),
            .c_i       (blk_c[k]),
            .carry_c_o (grp_c[4*k +: 4]),
            .grp_p_c_o (blk_p[k]),
            .grp_g_c_o (blk_g[k])
        );
    end

    // Level 3: carries into bits 0/16/32/48 from cin.
    cla_lookahead4 u_top (
        .p_i       (blk_p),
        .g_i       (blk_g),
        .c_i       (cin),
        .carry_c_o (blk_c),
        .grp_p_c_o (top_p),
        .grp_g_c_o (top_g)
    );

    always_comb begin
        c64    = top_g | (top_p & cin);
        sum_d  = bit_p ^ bit_c;
        cout_d = c64;
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_cla_64bit_adder.sv
// Self-checking bench: directed corner cases plus random vectors against a 65-bit arithmetic model.

module tb_cla_64bit_adder;

    logic        CLK;
    logic        reset;
    logic [63:0] in_a;
    logic [63:0] in_b;
    logic        cin;
    logic [63:0] sum;
    logic        cout;

    int          vectors;
    int          miscompares;
    logic [64:0] exp_q;

    cla_64bit_adder dut (
        .CLK   (CLK),
        .reset (reset),
        .in_a  (in_a),
        .in_b  (in_b),
        .cin   (cin),
        .sum   (sum),
        .cout  (cout)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [64:0] ref_add(input logic [63:0] a, input logic [63:0] b, input logic c);
        return {1'b0, a} + {1'b0, b} + 65'(c);
    endfunction

    task automatic check(input string tag, input logic [64:0] expv);
        vectors++;
        assert ({cout, sum} === expv) else begin
            miscompares++;
            $error("FAIL %s: got cout=%b sum=%h, expected cout=%b sum=%h",
                   tag, cout, sum, expv[64], expv[63:0]);
        end
    endtask

    // Called just after a rising edge: drive operands, confirm the previous result holds, then check the new one.
    task automatic step(input logic [63:0] a, input logic [63:0] b, input logic c, input string tag);
        logic [64:0] r;
        in_a = a;
        in_b = b;
        cin  = c;
        @(negedge CLK);
        check({tag, "_hold"}, exp_q);
        r = ref_add(a, b, c);
        @(posedge CLK);
        #1;
        check(tag, r);
        exp_q = r;
    endtask

    // Short asynchronous reset pulse that ends before the next rising edge.
    task automatic reset_pulse(input string tag);
        reset = 1'b1;
        #1;
        check(tag, 65'd0);
        exp_q = 65'd0;
        #1;
        reset = 1'b0;
    endtask

    initial begin
        logic [63:0] ra;
        logic [63:0] rb;
        logic        rc;

        vectors     = 0;
        miscompares = 0;
        exp_q       = 65'd0;
        reset       = 1'b1;
        in_a        = 64'd0;
        in_b        = 64'd0;
        cin         = 1'b0;

        @(posedge CLK);
        #1;
        check("reset_state", 65'd0);

        // Load something nonzero, then show reset clears it without waiting for a clock.
        reset = 1'b0;
        step(64'd3, 64'd4, 1'b0, "pre_reset");
        in_a  = 64'd5;
        in_b  = 64'd7;
        reset = 1'b1;
        #1;
        check("reset_async", 65'd0);
        @(posedge CLK);
        #1;
        check("reset_held", 65'd0);
        exp_q = 65'd0;
        reset = 1'b0;
        step(64'd5, 64'd7, 1'b0, "reset_release");

        step(64'd0, 64'd0, 1'b0, "zero");
        step(64'd0, 64'd0, 1'b1, "zero_cin");
        step(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, "wrap_b0");
        step(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, "wrap_ones");
        step(64'h0000_0000_0000_000F, 64'd1, 1'b0, "carry_lvl1");
        step(64'h0000_0000_0000_FFFF, 64'd1, 1'b0, "carry_lvl2");
        step(64'h0000_FFFF_FFFF_FFFF, 64'd1, 1'b0, "carry_lvl3");
        step(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, "carry_msb");
        step(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, "cout_only");
        step(64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b1, "alt_prop");

        for (int i = 0; i < 40; i++) begin
            if (i % 2 == 0) begin
                ra = 64'($urandom) * 64'($urandom);
                rb = 64'($urandom) * 64'($urandom);
            end else begin
                ra = {$urandom, $urandom};
                rb = {$urandom, $urandom};
            end
            rc = 1'($urandom);
            step(ra, rb, rc, $sformatf("rand%0d", i));
            if (i % 8 == 7) reset_pulse($sformatf("rand_rst%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
